conv_stream_gen: RTL and testbench

- Sequencer that produces the input stream for the per-layer convolution accumulator arrays.
- Walks a KxK kernel window over a feature map held in a single-port SRAM. Each SRAM word packs INPUT_NUM channels.
- Issues feature-map and weight-ROM read addresses, then drives aa_en / aa_first_data / aa_last_data aligned with the returned SRAM data on image.
- Sits between the layer controller (start/done) and the accumulator array (aa_* / image).

---
 rtl/conv_stream_gen.sv | 149 ++++++++++++++
 tb/tb_conv_stream_gen.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/conv_stream_gen.sv
// Walks a KxK window over an SRAM-resident feature map and emits the read
// addresses plus the aa_* stream tags aligned with the returned SRAM data.
module conv_stream_gen #(
  parameter int IMG_W     = 6,
  parameter int IMG_H     = 6,
  parameter int K         = 3,
  parameter int STRIDE    = 1,
  parameter int WD        = 16,
  parameter int INPUT_NUM = 4,
  parameter int ADDR_W    = 10,
  parameter int WADDR_W   = 5
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic                    stall,
  output logic                    busy,
  output logic                    done,
  output logic                    fm_rd_en,
  output logic [ADDR_W-1:0]       fm_rd_addr,
  input  logic [WD*INPUT_NUM-1:0] fm_rd_data,
  output logic [WADDR_W-1:0]      wt_rd_addr,
  output logic                    aa_en,
  output logic                    aa_first_data,
  output logic                    aa_last_data,
  output logic [WD*INPUT_NUM-1:0] image
);
  localparam int OUT_W = (IMG_W - K) / STRIDE + 1;
  localparam int OUT_H = (IMG_H - K) / STRIDE + 1;
  localparam int KC_W  = (K > 1)     ? $clog2(K)     : 1;
  localparam int OX_W  = (OUT_W > 1) ? $clog2(OUT_W) : 1;
  localparam int OY_W  = (OUT_H > 1) ? $clog2(OUT_H) : 1;

  localparam logic [KC_W-1:0]    K_LAST  = KC_W'(K - 1);
  localparam logic [OX_W-1:0]    OX_LAST = OX_W'(OUT_W - 1);
  localparam logic [OY_W-1:0]    OY_LAST = OY_W'(OUT_H - 1);
  localparam logic [WADDR_W-1:0] W_LAST  = WADDR_W'(K * K - 1);
  localparam logic [ADDR_W-1:0]  A_ROW   = ADDR_W'(IMG_W);
  localparam logic [ADDR_W-1:0]  A_STEP  = ADDR_W'(STRIDE);
  localparam logic [ADDR_W-1:0]  A_WROW  = ADDR_W'(STRIDE * IMG_W);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;
  typedef struct packed {
    logic first;
    logic last;
  } tag_t;

  state_t            state, state_nxt;
  logic [KC_W-1:0]   kx, ky;
  logic [OX_W-1:0]   ox;
  logic [OY_W-1:0]   oy;
  logic [ADDR_W-1:0] oy_base, win_base, row_base;
  logic [1:0]        vld_pipe;
  tag_t              tag_q;
  logic              issue, kx_end, ky_end, ox_end, oy_end, last_issue;

  assign issue      = (state == S_RUN) && !stall;
  assign kx_end     = (kx == K_LAST);
  assign ky_end     = (ky == K_LAST);
  assign ox_end     = (ox == OX_LAST);
  assign oy_end     = (oy == OY_LAST);
  assign last_issue = issue && kx_end && ky_end && ox_end && oy_end;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    busy      = (state != S_IDLE);
    done      = (state == S_DONE);
    fm_rd_en  = issue;
    case (state)
      S_IDLE:  if (start) state_nxt = S_RUN;
      S_RUN:   if (last_issue) state_nxt = S_DRAIN;
      S_DRAIN: state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Address is built from three nested bases (window-row, window, kernel-row)
  // so every step is a single add; the final wrap lands everything back on 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      kx <= '0; ky <= '0; ox <= '0; oy <= '0;
      oy_base <= '0; win_base <= '0; row_base <= '0;
      fm_rd_addr <= '0; wt_rd_addr <= '0;
    end else if (state == S_IDLE && start) begin
      kx <= '0; ky <= '0; ox <= '0; oy <= '0;
      oy_base <= '0; win_base <= '0; row_base <= '0;
      fm_rd_addr <= '0; wt_rd_addr <= '0;
    end else if (issue) begin
      wt_rd_addr <= (wt_rd_addr == W_LAST) ? '0 : wt_rd_addr + 1'b1;
      if (!kx_end) begin
        kx         <= kx + 1'b1;
        fm_rd_addr <= fm_rd_addr + 1'b1;
      end else begin
        kx <= '0;
        if (!ky_end) begin
          ky         <= ky + 1'b1;
          row_base   <= row_base + A_ROW;
          fm_rd_addr <= row_base + A_ROW;
        end else begin
          ky <= '0;
          if (!ox_end) begin
            ox         <= ox + 1'b1;
            win_base   <= win_base + A_STEP;
            row_base   <= win_base + A_STEP;
            fm_rd_addr <= win_base + A_STEP;
          end else begin
            ox <= '0;
            if (!oy_end) begin
              oy         <= oy + 1'b1;
              oy_base    <= oy_base + A_WROW;
              win_base   <= oy_base + A_WROW;
              row_base   <= oy_base + A_WROW;
              fm_rd_addr <= oy_base + A_WROW;
            end else begin
              oy <= '0; oy_base <= '0; win_base <= '0; row_base <= '0;
              fm_rd_addr <= '0;
            end
          end
        end
      end
    end
  end

  // One-stage valid/tag pipe matching the SRAM read latency.
  assign vld_pipe[0] = issue;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe[1] <= 1'b0;
      tag_q       <= '0;
    end else begin
      vld_pipe[1] <= vld_pipe[0];
      tag_q.first <= issue && (kx == '0) && (ky == '0);
      tag_q.last  <= issue && kx_end && ky_end;
    end
  end

  assign aa_en         = vld_pipe[1];
  assign aa_first_data = tag_q.first;
  assign aa_last_data  = tag_q.last;
  assign image         = fm_rd_data;

endmodule

// File: tb/tb_conv_stream_gen.sv
// Bench for conv_stream_gen: default 6x6/K3/S1 instance and a 7x7/K3/S2 instance,
// each checked against a nested-loop window model and an addr-as-data SRAM.
module tb_conv_stream_gen;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start[2], stall[2];
  logic       busy[2], done[2], fm_en[2], en[2], first[2], last[2];
  logic [9:0] addr[2];
  logic [4:0] wt[2];
  logic [63:0] rdata[2], image[2];

  always #5 clk = ~clk;

  conv_stream_gen u_a (
    .clk(clk), .rst_n(rst_n), .start(start[0]), .stall(stall[0]),
    .busy(busy[0]), .done(done[0]), .fm_rd_en(fm_en[0]), .fm_rd_addr(addr[0]),
    .fm_rd_data(rdata[0]), .wt_rd_addr(wt[0]), .aa_en(en[0]),
    .aa_first_data(first[0]), .aa_last_data(last[0]), .image(image[0]));

  conv_stream_gen #(.IMG_W(7), .IMG_H(7), .K(3), .STRIDE(2)) u_b (
    .clk(clk), .rst_n(rst_n), .start(start[1]), .stall(stall[1]),
    .busy(busy[1]), .done(done[1]), .fm_rd_en(fm_en[1]), .fm_rd_addr(addr[1]),
    .fm_rd_data(rdata[1]), .wt_rd_addr(wt[1]), .aa_en(en[1]),
    .aa_first_data(first[1]), .aa_last_data(last[1]), .image(image[1]));

  function automatic logic [63:0] fmdata(input int a);
    logic [15:0] v;
    v = 16'(a);
    return {v + 16'd3000, v + 16'd2000, v + 16'd1000, v};
  endfunction

  // SRAM: one-cycle latency, garbage when not read
  always @(posedge clk)
    for (int d = 0; d < 2; d++)
      rdata[d] <= fm_en[d] ? fmdata(int'(addr[d])) : 64'hDEAD_BEEF_0BAD_F00D;

  int tests = 0, fails = 0;
  int sel = 0, cyc = 0, start_cyc = 0, busy_cnt = 0, tag_err = 0, base_done_rel = 0;
  int iss_addr[$], iss_wt[$], iss_cyc[$], tap_cyc[$], done_cyc[$];
  logic [63:0] tap_img[$];
  bit tap_first[$], tap_last[$];
  int exp_addr[$], exp_wt[$];
  bit exp_first[$], exp_last[$];

  always @(negedge clk) begin
    cyc++;
    if (fm_en[sel]) begin
      iss_addr.push_back(int'(addr[sel])); iss_wt.push_back(int'(wt[sel])); iss_cyc.push_back(cyc);
    end
    if (en[sel]) begin
      tap_img.push_back(image[sel]); tap_first.push_back(first[sel]);
      tap_last.push_back(last[sel]); tap_cyc.push_back(cyc);
    end
    if (done[sel]) done_cyc.push_back(cyc);
    if (busy[sel]) busy_cnt++;
    if (!en[sel] && (first[sel] || last[sel])) tag_err++;
  end

  task automatic build_model(input int iw, input int ih, input int k, input int s);
    exp_addr.delete(); exp_wt.delete(); exp_first.delete(); exp_last.delete();
    for (int oy = 0; oy < (ih - k) / s + 1; oy++)
      for (int ox = 0; ox < (iw - k) / s + 1; ox++)
        for (int ky = 0; ky < k; ky++)
          for (int kx = 0; kx < k; kx++) begin
            exp_addr.push_back((oy * s + ky) * iw + ox * s + kx);
            exp_wt.push_back(ky * k + kx);
            exp_first.push_back(ky == 0 && kx == 0);
            exp_last.push_back(ky == k - 1 && kx == k - 1);
          end
  endtask

  function automatic int stream_errs();
    int e = 0;
    if (iss_addr.size() != exp_addr.size() || tap_img.size() != exp_addr.size()) return 1000;
    for (int i = 0; i < exp_addr.size(); i++) begin
      if (iss_addr[i] != exp_addr[i] || iss_wt[i] != exp_wt[i]) e++;
      if (tap_img[i] !== fmdata(exp_addr[i])) e++;
      if (tap_first[i] != exp_first[i] || tap_last[i] != exp_last[i]) e++;
      if (tap_cyc[i] != iss_cyc[i] + 1) e++;
    end
    return e;
  endfunction

  function automatic int count_bits(input bit which_last);
    int n = 0;
    for (int i = 0; i < tap_first.size(); i++) n += which_last ? int'(tap_last[i]) : int'(tap_first[i]);
    return n;
  endfunction

  task automatic clear_obs();
    iss_addr.delete(); iss_wt.delete(); iss_cyc.delete(); tap_cyc.delete(); done_cyc.delete();
    tap_img.delete(); tap_first.delete(); tap_last.delete();
    busy_cnt = 0; tag_err = 0;
  endtask

  // smode: 0 none, 1 hold stall for sb cycles once sa reads issued, 2 random
  task automatic run_pass(input int smode, input int sa, input int sb, input int restart_at,
                          output bit tmo);
    int held = 0;
    clear_obs();
    @(posedge clk); #1 start[sel] = 1'b1;
    @(negedge clk); #1 start_cyc = cyc;
    @(posedge clk); #1 start[sel] = 1'b0;
    tmo = 1'b1;
    for (int c = 0; c < 3000; c++) begin
      start[sel] = (c == restart_at);
      stall[sel] = 1'b0;
      if (smode == 1 && iss_addr.size() == sa && held < sb) begin stall[sel] = 1'b1; held++; end
      if (smode == 2) stall[sel] = ($urandom_range(3) == 0);
      @(posedge clk); #1;
      if (done_cyc.size() > 0) begin tmo = 1'b0; break; end
    end
    start[sel] = 1'b0; stall[sel] = 1'b0;
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [20:0] v;
    for (int d = 0; d < 2; d++) begin
      v = {busy[d], done[d], fm_en[d], en[d], first[d], last[d], addr[d], wt[d]};
      tests++;
      if (v !== 21'd0) begin fails++; $display("FAIL reset_outputs dut%0d: got %h want 0", d, v); end
    end
  endtask

  task automatic test_full_pass();
    bit tmo;
    int w0[9] = '{0, 1, 2, 6, 7, 8, 12, 13, 14};
    int wl[9] = '{21, 22, 23, 27, 28, 29, 33, 34, 35};
    int e;
    sel = 0; build_model(6, 6, 3, 1);
    run_pass(0, 0, 0, -1, tmo);
    tests++; if (tmo) begin fails++; $display("FAIL full_timeout: no done within bound"); end
    tests++; if (tap_img.size() != 144) begin fails++; $display("FAIL full_taps: got %0d want 144", tap_img.size()); end
    tests++; if (count_bits(0) != 16 || count_bits(1) != 16) begin
      fails++; $display("FAIL full_tags: first %0d last %0d want 16/16", count_bits(0), count_bits(1)); end
    tests++; if (busy_cnt != 146) begin fails++; $display("FAIL full_busy: got %0d want 146", busy_cnt); end
    e = stream_errs();
    tests++; if (e != 0) begin fails++; $display("FAIL full_stream: %0d mismatches vs model", e); end
    e = 0;
    for (int i = 0; i < 9; i++)
      if (iss_addr.size() < 144 || iss_addr[i] != w0[i] || iss_wt[i] != i || iss_addr[135+i] != wl[i]) e++;
    tests++; if (e != 0) begin fails++; $display("FAIL full_window_addrs: %0d bad entries in first/last window", e); end
    tests++; if (iss_addr.size() < 37 || iss_addr[9] != 1 || iss_addr[36] != 6) begin
      fails++; $display("FAIL full_window_order: win2/win5 start wrong (want 1, 6)"); end
    tests++; if (tap_img.size() != 144 || !tap_last[143] || tap_img[143] !== fmdata(35)) begin
      fails++; $display("FAIL full_last_tap: last tap not address 35 with aa_last_data"); end
    tests++; if (done_cyc.size() != 1 || tap_cyc.size() == 0 || done_cyc[0] != tap_cyc[tap_cyc.size()-1] + 1) begin
      fails++; $display("FAIL full_done: %0d done pulses, want one 1 cycle after last tap", done_cyc.size()); end
    tests++; if (iss_cyc.size() == 0 || iss_cyc[0] != start_cyc + 1) begin
      fails++; $display("FAIL full_start_latency: first read at %0d want %0d", iss_cyc.size() ? iss_cyc[0] : -1, start_cyc + 1); end
    tests++; if (tag_err != 0) begin fails++; $display("FAIL full_tag_without_en: %0d cycles", tag_err); end
    base_done_rel = (done_cyc.size() > 0) ? done_cyc[0] - start_cyc : 0;
  endtask

  task automatic test_stall();
    bit tmo;
    int e;
    sel = 0; build_model(6, 6, 3, 1);
    run_pass(1, 4, 3, -1, tmo);
    tests++; if (tmo) begin fails++; $display("FAIL stall_timeout: no done within bound"); end
    e = stream_errs();
    tests++; if (e != 0) begin fails++; $display("FAIL stall_stream: %0d mismatches vs model", e); end
    tests++; if (tap_cyc.size() < 5 || tap_cyc[4] - tap_cyc[3] != 4 || iss_addr[4] != 7 || tap_first[4]) begin
      fails++; $display("FAIL stall_gap: tap5 gap/addr/first wrong (want gap 4 cycles, addr 7, first 0)"); end
    tests++; if (count_bits(0) != 16 || tap_img.size() != 144) begin
      fails++; $display("FAIL stall_totals: taps %0d firsts %0d want 144/16", tap_img.size(), count_bits(0)); end
    tests++; if (done_cyc.size() != 1 || done_cyc[0] - start_cyc != base_done_rel + 3) begin
      fails++; $display("FAIL stall_done_delay: got %0d want %0d", done_cyc.size() ? done_cyc[0] - start_cyc : -1, base_done_rel + 3); end
  endtask

  task automatic test_restart_ignored();
    bit tmo;
    sel = 0; build_model(6, 6, 3, 1);
    run_pass(0, 0, 0, 49, tmo);
    tests++; if (tmo || tap_img.size() != 144 || done_cyc.size() != 1) begin
      fails++; $display("FAIL restart_ignored: taps %0d done %0d want 144/1", tap_img.size(), done_cyc.size()); end
    tests++; if (stream_errs() != 0) begin fails++; $display("FAIL restart_stream: %0d mismatches", stream_errs()); end
  endtask

  task automatic test_mid_reset();
    bit tmo;
    logic [20:0] v;
    sel = 0; build_model(6, 6, 3, 1);
    clear_obs();
    @(posedge clk); #1 start[0] = 1'b1;
    @(posedge clk); #1 start[0] = 1'b0;
    repeat (59) @(posedge clk);
    #1 rst_n = 1'b0;
    #1 v = {busy[0], done[0], fm_en[0], en[0], first[0], last[0], addr[0], wt[0]};
    tests++; if (v !== 21'd0) begin fails++; $display("FAIL midreset_outputs: got %h want 0", v); end
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    tests++; if (done_cyc.size() != 0) begin fails++; $display("FAIL midreset_no_done: got %0d pulses want 0", done_cyc.size()); end
    run_pass(0, 0, 0, -1, tmo);
    tests++; if (tmo || tap_img.size() != 144 || iss_addr.size() == 0 || iss_addr[0] != 0) begin
      fails++; $display("FAIL midreset_restart: taps %0d want 144 from addr 0", tap_img.size()); end
    tests++; if (stream_errs() != 0) begin fails++; $display("FAIL midreset_stream: %0d mismatches", stream_errs()); end
  endtask

  task automatic test_random_stall();
    bit tmo;
    for (int r = 0; r < 3; r++) begin
      sel = 0; build_model(6, 6, 3, 1);
      run_pass(2, 0, 0, -1, tmo);
      tests++; if (tmo || stream_errs() != 0 || done_cyc.size() != 1 || tag_err != 0) begin
        fails++; $display("FAIL rand_stall run%0d: tmo %0d mismatches %0d done %0d", r, tmo, stream_errs(), done_cyc.size()); end
    end
  endtask

  task automatic test_stride2();
    bit tmo;
    sel = 1; build_model(7, 7, 3, 2);
    run_pass(0, 0, 0, -1, tmo);
    tests++; if (tmo || tap_img.size() != 81 || count_bits(1) != 9) begin
      fails++; $display("FAIL stride2_taps: got %0d want 81", tap_img.size()); end
    tests++; if (iss_addr.size() < 28 || iss_addr[9] != 2 || iss_addr[27] != 14) begin
      fails++; $display("FAIL stride2_window_start: win1/win3 wrong (want 2, 14)"); end
    tests++; if (stream_errs() != 0) begin fails++; $display("FAIL stride2_stream: %0d mismatches", stream_errs()); end
    run_pass(2, 0, 0, -1, tmo);
    tests++; if (tmo || stream_errs() != 0 || done_cyc.size() != 1) begin
      fails++; $display("FAIL stride2_rand_stall: tmo %0d mismatches %0d", tmo, stream_errs()); end
  endtask

  initial begin
    for (int d = 0; d < 2; d++) begin start[d] = 1'b0; stall[d] = 1'b0; end
    repeat (3) @(posedge clk);
    #1 test_reset();
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    test_full_pass();
    test_stall();
    test_restart_ignored();
    test_mid_reset();
    test_random_stall();
    test_stride2();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
